// File: rtl/carry_lookahead_stage.sv
// Two-stage block-carry lookahead feeding the 24-bit carry-select final adder.
// S1 registers rows plus per-block generate/propagate; S2 resolves the block carries.

module carry_lookahead_block_gp #(
    parameter int BLOCK_W = 4
) (
    input  logic [BLOCK_W-1:0] a_i,
    input  logic [BLOCK_W-1:0] b_i,
    output logic               g_o,
    output logic               p_o
);
    logic [BLOCK_W:0] sum;

    always_comb sum = {1'b0, a_i} + {1'b0, b_i};

    assign g_o = sum[BLOCK_W];
    assign p_o = &(a_i ^ b_i);
endmodule

module carry_lookahead_stage #(
    parameter int N_BLOCKS = 6,
    parameter int BLOCK_W  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_BLOCKS*BLOCK_W-1:0]   a_in,
    input  logic [N_BLOCKS*BLOCK_W-1:0]   b_in,
    input  logic                          c_in0,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N_BLOCKS*BLOCK_W-1:0]   a_out,
    output logic [N_BLOCKS*BLOCK_W-1:0]   b_out,
    output logic [N_BLOCKS-1:0]           c_blk,
    output logic                          c_out
);
    localparam int W = N_BLOCKS * BLOCK_W;

    logic                s1_valid_q;
    logic [W-1:0]        s1_a_q, s1_b_q;
    logic                s1_cin_q;
    logic [N_BLOCKS-1:0] s1_g_q, s1_p_q;

    logic                out_valid_q;
    logic [W-1:0]        a_out_q, b_out_q;
    logic [N_BLOCKS-1:0] c_blk_q;
    logic                c_out_q;

    logic [N_BLOCKS-1:0] g_d, p_d;
    logic [N_BLOCKS:0]   c_d;
    logic                s1_en, s2_en;

    // Each stage is a full-rate register: it may load whenever its downstream
    // slot is empty or being drained in the same cycle.
    assign s2_en    = !out_valid_q | out_ready;
    assign s1_en    = !s1_valid_q | s2_en;
    assign in_ready = s1_en & !rst;

    for (genvar i = 0; i < N_BLOCKS; i++) begin : g_blk
        carry_lookahead_block_gp #(.BLOCK_W(BLOCK_W)) u_gp (
            .a_i (a_in[i*BLOCK_W +: BLOCK_W]),
            .b_i (b_in[i*BLOCK_W +: BLOCK_W]),
            .g_o (g_d[i]),
            .p_o (p_d[i])
        );
    end

    always_comb begin
        c_d    = '0;
        c_d[0] = s1_cin_q;
        for (int i = 0; i < N_BLOCKS; i++)
            c_d[i+1] = s1_g_q[i] | (s1_p_q[i] & c_d[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_cin_q    <= 1'b0;
            s1_g_q      <= '0;
            s1_p_q      <= '0;
            out_valid_q <= 1'b0;
            a_out_q     <= '0;
            b_out_q     <= '0;
            c_blk_q     <= '0;
            c_out_q     <= 1'b0;
        end else begin
            if (s1_en) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_a_q   <= a_in;
                    s1_b_q   <= b_in;
                    s1_cin_q <= c_in0;
                    s1_g_q   <= g_d;
                    s1_p_q   <= p_d;
                end
            end
            if (s2_en) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    a_out_q <= s1_a_q;
                    b_out_q <= s1_b_q;
                    c_blk_q <= c_d[N_BLOCKS-1:0];
                    c_out_q <= c_d[N_BLOCKS];
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign a_out     = a_out_q;
    assign b_out     = b_out_q;
    assign c_blk     = c_blk_q;
    assign c_out     = c_out_q;
endmodule

// File: tb/tb_carry_lookahead_stage.sv
// Bench for carry_lookahead_stage: arithmetic reference model with an in-flight
// queue, plus directed literal vectors.

module tb_carry_lookahead_stage;
    logic        clk, rst, in_valid, in_ready, c_in0, out_valid, out_ready, c_out;
    logic [23:0] a_in, b_in, a_out, b_out;
    logic [5:0]  c_blk;

    carry_lookahead_stage #(.N_BLOCKS(6), .BLOCK_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .c_in0(c_in0),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_out(a_out), .b_out(b_out), .c_blk(c_blk), .c_out(c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        logic [5:0]  blk;
        logic        cout;
    } exp_t;

    exp_t q[$];
    int   cmp_cnt = 0;
    int   err_cnt = 0;
    int   out_cnt = 0;
    int   in_cnt  = 0;
    int   stall_cycles = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Carry into bit 4i is bit 4i of the sum of the operands truncated below 4i.
    function automatic logic [6:0] model(input logic [23:0] a, input logic [23:0] b, input logic cin);
        logic [24:0] m, s;
        logic [5:0]  blk;
        for (int i = 0; i < 6; i++) begin
            m      = (25'd1 << (4*i)) - 25'd1;
            s      = ({1'b0, a} & m) + ({1'b0, b} & m) + {24'd0, cin};
            blk[i] = s[4*i];
        end
        s = {1'b0, a} + {1'b0, b} + {24'd0, cin};
        return {s[24], blk};
    endfunction

    exp_t        e;
    logic        stall_q = 1'b0;
    logic [23:0] pa, pb;
    logic [5:0]  pblk;
    logic        pcout;

    always @(negedge clk) begin
        if (rst) begin
            chk("in_ready_in_reset", {63'd0, in_ready}, 64'd0);
            q.delete();
            stall_q = 1'b0;
        end else begin
            chk("in_ready", {63'd0, in_ready}, {63'd0, !(q.size() == 2 && !out_ready)});
            if (q.size() == 0) chk("out_valid_when_empty", {63'd0, out_valid}, 64'd0);
            if (q.size() == 2) chk("out_valid_when_full", {63'd0, out_valid}, 64'd1);
            if (in_ready == 1'b0) stall_cycles++;
            if (stall_q) begin
                chk("stall_valid", {63'd0, out_valid}, 64'd1);
                chk("stall_a", {40'd0, a_out}, {40'd0, pa});
                chk("stall_b", {40'd0, b_out}, {40'd0, pb});
                chk("stall_blk", {58'd0, c_blk}, {58'd0, pblk});
                chk("stall_cout", {63'd0, c_out}, {63'd0, pcout});
            end
            if (out_valid && out_ready) begin
                out_cnt++;
                if (q.size() == 0) begin
                    cmp_cnt++;
                    err_cnt++;
                    $display("FAIL out_underflow: got output fire expected none at %0t", $time);
                end else begin
                    e = q.pop_front();
                    chk("out_a", {40'd0, a_out}, {40'd0, e.a});
                    chk("out_b", {40'd0, b_out}, {40'd0, e.b});
                    chk("out_blk", {58'd0, c_blk}, {58'd0, e.blk});
                    chk("out_cout", {63'd0, c_out}, {63'd0, e.cout});
                end
            end
            if (in_valid && in_ready) begin
                in_cnt++;
                e.a = a_in;
                e.b = b_in;
                {e.cout, e.blk} = model(a_in, b_in, c_in0);
                q.push_back(e);
            end
            stall_q = out_valid && !out_ready;
            pa = a_out; pb = b_out; pblk = c_blk; pcout = c_out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dir(input string nm, input logic [23:0] a, input logic [23:0] b,
                       input logic cin, input logic [5:0] eblk, input logic ecout);
        a_in = a; b_in = b; c_in0 = cin; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({nm, "_valid_e1"}, {63'd0, out_valid}, 64'd0);
        tick();
        chk({nm, "_valid_e2"}, {63'd0, out_valid}, 64'd1);
        chk({nm, "_blk"}, {58'd0, c_blk}, {58'd0, eblk});
        chk({nm, "_cout"}, {63'd0, c_out}, {63'd0, ecout});
        chk({nm, "_a"}, {40'd0, a_out}, {40'd0, a});
        chk({nm, "_b"}, {40'd0, b_out}, {40'd0, b});
        tick();
        chk({nm, "_valid_e3"}, {63'd0, out_valid}, 64'd0);
    endtask

    int  start_out, start_in;
    bit  acc;

    initial begin
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        a_in = 24'h123456; b_in = 24'hABCDEF; c_in0 = 1'b1;

        // Pin the reference model against hand-worked carries.
        chk("model_single", {57'd0, model(24'h00000F, 24'h000001, 1'b0)}, {57'd0, 7'b0_000010});
        chk("model_prop",   {57'd0, model(24'hFFFFFF, 24'h000000, 1'b1)}, {57'd0, 7'b1_111111});
        chk("model_gen",    {57'd0, model(24'hFFFFFF, 24'hFFFFFF, 1'b0)}, {57'd0, 7'b1_111110});
        chk("model_alt",    {57'd0, model(24'h0F0F0F, 24'h010101, 1'b0)}, {57'd0, 7'b0_101010});

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
            chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
            chk("rst_a_out", {40'd0, a_out}, 64'd0);
            chk("rst_b_out", {40'd0, b_out}, 64'd0);
            chk("rst_c_blk", {58'd0, c_blk}, 64'd0);
            chk("rst_c_out", {63'd0, c_out}, 64'd0);
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        tick();

        dir("single", 24'h00000F, 24'h000001, 1'b0, 6'b000010, 1'b0);
        dir("ripple", 24'hFFFFFF, 24'h000000, 1'b1, 6'b111111, 1'b1);
        dir("gen",    24'hFFFFFF, 24'hFFFFFF, 1'b0, 6'b111110, 1'b1);

        // Back-to-back throughput.
        start_out = out_cnt;
        for (int i = 0; i < 100; i++) begin
            a_in = 24'($urandom); b_in = 24'($urandom); c_in0 = 1'($urandom);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        chk("thru_out_count", 64'(out_cnt - start_out), 64'd100);
        chk("thru_queue_empty", 64'(q.size()), 64'd0);

        // Random backpressure with continuous input.
        start_out = out_cnt; start_in = in_cnt; stall_cycles = 0;
        a_in = 24'($urandom); b_in = 24'($urandom); c_in0 = 1'($urandom);
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            out_ready = 1'($urandom);
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) begin
                a_in = 24'($urandom); b_in = 24'($urandom); c_in0 = 1'($urandom);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) tick();
        chk("bp_queue_empty", 64'(q.size()), 64'd0);
        chk("bp_in_eq_out", 64'(out_cnt - start_out), 64'(in_cnt - start_in));
        chk("bp_saw_stall", {63'd0, stall_cycles > 0}, 64'd1);

        // Reset with both stages full and stalled.
        out_ready = 1'b0; in_valid = 1'b1;
        a_in = 24'h111111; b_in = 24'h222222; c_in0 = 1'b0;
        tick();
        a_in = 24'h333333; b_in = 24'h444444;
        tick();
        in_valid = 1'b0;
        chk("mid_full_valid", {63'd0, out_valid}, 64'd1);
        chk("mid_full_in_ready", {63'd0, in_ready}, 64'd0);
        start_out = out_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_no_fire", 64'(out_cnt - start_out), 64'd0);
        chk("mid_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_in_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        tick();
        dir("after_rst", 24'h0F0F0F, 24'h010101, 1'b0, 6'b101010, 1'b0);
        chk("final_queue_empty", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
